// File: rtl/regfile_wb_sched_if.sv
// Bundle of the signals exchanged between the write-port scheduler and its
// neighbours: writeback stage, long-latency unit, decode stage and the
// register file write port.
//   slave  : the scheduler's view (requests in, write port/stall/ready out)
//   master : the surrounding pipeline's view
interface regfile_wb_sched_if #(
  parameter int WIDTH   = 32,
  parameter int R_WIDTH = 5
);
  // writeback stage
  logic               wb_we_i;
  logic [R_WIDTH-1:0] wb_addr_i;
  logic [WIDTH-1:0]   wb_data_i;
  // long-latency unit
  logic               lu_valid_i;
  logic [R_WIDTH-1:0] lu_addr_i;
  logic [WIDTH-1:0]   lu_data_i;
  logic               lu_ready_o;
  // decode stage
  logic [R_WIDTH-1:0] rs1_addr_i;
  logic [R_WIDTH-1:0] rs2_addr_i;
  logic [R_WIDTH-1:0] dst_addr_i;
  logic               iss_lu_i;
  logic               stall_o;
  // register file write port
  logic               write_d_o;
  logic [R_WIDTH-1:0] write_addr_o;
  logic [WIDTH-1:0]   write_data_o;

  modport slave (
    input  wb_we_i, wb_addr_i, wb_data_i,
    input  lu_valid_i, lu_addr_i, lu_data_i,
    output lu_ready_o,
    input  rs1_addr_i, rs2_addr_i, dst_addr_i, iss_lu_i,
    output stall_o,
    output write_d_o, write_addr_o, write_data_o
  );

  modport master (
    output wb_we_i, wb_addr_i, wb_data_i,
    output lu_valid_i, lu_addr_i, lu_data_i,
    input  lu_ready_o,
    output rs1_addr_i, rs2_addr_i, dst_addr_i, iss_lu_i,
    input  stall_o,
    input  write_d_o, write_addr_o, write_data_o
  );
endinterface

// File: rtl/regfile_wb_sched.sv
// Write-port scheduler and busy-bit scoreboard for the register file.
// The single write port is shared between the in-order writeback stage
// (always wins, never delayed) and a long-latency unit whose results wait
// in a small FIFO until the port is free. Busy bits track registers with a
// long-latency result in flight and produce the decode stall.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : regfile_wb_sched_if.slave (WB, LU, decode and write-port signals)
module regfile_wb_sched #(
  parameter int WIDTH      = 32,
  parameter int R_WIDTH    = 5,
  parameter int REGSIZE    = 32,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  regfile_wb_sched_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [R_WIDTH-1:0] fifo_addr_q [DEPTH];
  logic [R_WIDTH-1:0] fifo_addr_d [DEPTH];
  logic [WIDTH-1:0]   fifo_data_q [DEPTH];
  logic [WIDTH-1:0]   fifo_data_d [DEPTH];
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [REGSIZE-1:0] busy_q, busy_d;
  logic [SW-1:0]      sc_q, sc_d;

  logic               fifo_empty;
  logic               lu_ready;
  logic               push;
  logic               pop;
  logic               starved;
  logic               stall;
  logic               issue_set;
  logic [R_WIDTH-1:0] head_addr;
  logic [WIDTH-1:0]   head_data;

  assign head_addr  = fifo_addr_q[rd_ptr_q];
  assign head_data  = fifo_data_q[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  // Ready looks only at the registered count: a same-cycle pop never frees
  // space, which keeps lu_ready_o off any combinational path from wb_we_i.
  assign lu_ready   = !rst_i && (count_q != CW'(DEPTH));
  assign push       = bus.lu_valid_i && lu_ready;
  assign pop        = !rst_i && !bus.wb_we_i && !fifo_empty;
  assign starved    = (sc_q >= SW'(STARVE_MAX));
  assign stall      = !rst_i && (busy_q[bus.rs1_addr_i] || busy_q[bus.rs2_addr_i] ||
                                 busy_q[bus.dst_addr_i] || starved);
  assign issue_set  = bus.iss_lu_i && !stall && (bus.dst_addr_i != '0);

  assign bus.lu_ready_o = lu_ready;
  assign bus.stall_o    = stall;

  // Write-port mux: WB first, otherwise the FIFO head (which pops at the edge).
  always_comb begin
    bus.write_d_o    = 1'b0;
    bus.write_addr_o = '0;
    bus.write_data_o = '0;
    if (!rst_i) begin
      if (bus.wb_we_i) begin
        bus.write_d_o    = 1'b1;
        bus.write_addr_o = bus.wb_addr_i;
        bus.write_data_o = bus.wb_data_i;
      end else if (!fifo_empty) begin
        bus.write_d_o    = 1'b1;
        bus.write_addr_o = head_addr;
        bus.write_data_o = head_data;
      end
    end
  end

  // FIFO storage, pointers, count and starvation counter.
  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (push) begin
      fifo_addr_d[wr_ptr_q] = bus.lu_addr_i;
      fifo_data_d[wr_ptr_q] = bus.lu_data_i;
      wr_ptr_d              = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    // A non-empty FIFO that did not pop means WB took the port this cycle.
    sc_d = sc_q;
    if (fifo_empty || pop) begin
      sc_d = '0;
    end else if (bus.wb_we_i && !starved) begin
      sc_d = sc_q + SW'(1);
    end
  end

  // Busy bits: r0 is hardwired clear; a same-cycle issue beats the clear.
  for (genvar gi = 0; gi < REGSIZE; gi++) begin : g_busy
    if (gi == 0) begin : g_r0
      assign busy_d[gi] = 1'b0;
    end else begin : g_rn
      logic set_hit;
      logic clr_hit;
      assign set_hit    = issue_set && (bus.dst_addr_i == R_WIDTH'(gi));
      assign clr_hit    = pop && (head_addr == R_WIDTH'(gi));
      assign busy_d[gi] = set_hit || (busy_q[gi] && !clr_hit);
    end
  end

  always_ff @(posedge clk_i) begin
    // Payload needs no reset: it is only visible once count_q says so.
    fifo_addr_q <= fifo_addr_d;
    fifo_data_q <= fifo_data_d;
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= '0;
      sc_q     <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      sc_q     <= sc_d;
    end
  end
endmodule

// File: tb/tb_regfile_wb_sched.sv
module tb_regfile_wb_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_sched_if #(.WIDTH(32), .R_WIDTH(5)) bus ();

  regfile_wb_sched #(
    .WIDTH(32), .R_WIDTH(5), .REGSIZE(32), .DEPTH(2), .STARVE_MAX(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t lu_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.wb_we_i    = 1'b0;
    bus.wb_addr_i  = '0;
    bus.wb_data_i  = '0;
    bus.lu_valid_i = 1'b0;
    bus.lu_addr_i  = '0;
    bus.lu_data_i  = '0;
    bus.rs1_addr_i = '0;
    bus.rs2_addr_i = '0;
    bus.dst_addr_i = '0;
    bus.iss_lu_i   = 1'b0;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    bus.wb_we_i   = 1'b1;
    bus.wb_addr_i = a;
    bus.wb_data_i = d;
  endtask

  // Drive an LU result; the expectation is queued only when acceptance is expected.
  task automatic lu(input logic [4:0] a, input logic [31:0] d, input bit accept);
    bus.lu_valid_i = 1'b1;
    bus.lu_addr_i  = a;
    bus.lu_data_i  = d;
    if (accept) lu_q.push_back({a, d});
  endtask

  // Scoreboard side: every port write is either the WB request of this cycle
  // or the oldest accepted LU result.
  always @(negedge clk) begin
    wr_t e;
    if (!rst && bus.write_d_o === 1'b1) begin
      $display("write r%0d = 0x%08h (%s)", bus.write_addr_o, bus.write_data_o,
               bus.wb_we_i ? "wb" : "lu");
      if (bus.wb_we_i) begin
        chk("wb_addr", 32'(bus.write_addr_o), 32'(bus.wb_addr_i));
        chk("wb_data", bus.write_data_o, bus.wb_data_i);
      end else if (lu_q.size() == 0) begin
        chk("spurious_write", 32'(bus.write_d_o), 32'd0);
      end else begin
        e = lu_q.pop_front();
        chk("lu_addr", 32'(bus.write_addr_o), 32'(e.a));
        chk("lu_data", bus.write_data_o, e.d);
      end
    end
  end

  initial begin
    // Reset with busy-looking inputs: nothing may leak out or be captured.
    idle_inputs();
    rst = 1'b1;
    wb(5'd3, 32'h3);
    lu(5'd4, 32'h4, 1'b0);
    bus.iss_lu_i   = 1'b1;
    bus.dst_addr_i = 5'd4;
    bus.rs1_addr_i = 5'd4;
    for (int i = 0; i < 2; i++) begin
      mid();
      chk("rst_write_d", 32'(bus.write_d_o), 32'd0);
      chk("rst_lu_ready", 32'(bus.lu_ready_o), 32'd0);
      chk("rst_stall", 32'(bus.stall_o), 32'd0);
      step();
    end
    rst = 1'b0;
    idle_inputs();

    // Idle after reset
    mid();
    chk("idle_write_d", 32'(bus.write_d_o), 32'd0);
    chk("idle_lu_ready", 32'(bus.lu_ready_o), 32'd1);
    chk("idle_stall", 32'(bus.stall_o), 32'd0);
    chk("idle_busy", dut.busy_q, 32'd0);
    step();

    // Issue LU op to r5, then a dependent decode
    bus.iss_lu_i = 1'b1; bus.dst_addr_i = 5'd5;
    mid(); chk("issue_r5_stall", 32'(bus.stall_o), 32'd0);
    step();
    idle_inputs();
    bus.rs1_addr_i = 5'd5;
    lu(5'd5, 32'hDEADBEEF, 1'b1);
    mid();
    chk("dep_stall", 32'(bus.stall_o), 32'd1);
    chk("push_ready", 32'(bus.lu_ready_o), 32'd1);
    chk("no_bypass", 32'(bus.write_d_o), 32'd0);
    step();                                  // edge k: result accepted
    bus.lu_valid_i = 1'b0;
    mid();
    chk("lu_write_d", 32'(bus.write_d_o), 32'd1);
    chk("stall_until_k1", 32'(bus.stall_o), 32'd1);
    step();                                  // edge k+1: written, busy cleared
    mid(); chk("dep_released", 32'(bus.stall_o), 32'd0);
    step();

    // WB priority over a queued LU result
    idle_inputs();
    lu(5'd7, 32'h11, 1'b1);
    step();
    bus.lu_valid_i = 1'b0;
    wb(5'd3, 32'h33);
    mid(); chk("wb_prio_addr", 32'(bus.write_addr_o), 32'd3);
    step();
    bus.wb_we_i = 1'b0;
    mid(); chk("queued_r7_addr", 32'(bus.write_addr_o), 32'd7);
    step();
    mid(); chk("drained_write_d", 32'(bus.write_d_o), 32'd0);
    step();

    // Full FIFO while WB holds the port
    wb(5'd1, 32'h101); lu(5'd10, 32'hA0, 1'b1);
    mid(); chk("full_rdy0", 32'(bus.lu_ready_o), 32'd1);
    step();
    wb(5'd1, 32'h102); lu(5'd11, 32'hB0, 1'b1);
    mid(); chk("full_rdy1", 32'(bus.lu_ready_o), 32'd1);
    step();
    wb(5'd1, 32'h103); lu(5'd12, 32'hC0, 1'b0);
    mid(); chk("full_not_ready", 32'(bus.lu_ready_o), 32'd0);
    step();
    bus.wb_we_i = 1'b0;                      // pop now, but no space this cycle
    mid(); chk("pop_no_space", 32'(bus.lu_ready_o), 32'd0);
    step();
    lu(5'd12, 32'hC0, 1'b1);                 // held result accepted after the pop
    mid(); chk("ready_after_pop", 32'(bus.lu_ready_o), 32'd1);
    step();
    bus.lu_valid_i = 1'b0;
    mid(); chk("pop_r12_write_d", 32'(bus.write_d_o), 32'd1);
    step();
    mid(); chk("full_drained", 32'(bus.write_d_o), 32'd0);
    step();

    // Starvation: head waits behind WB for STARVE_MAX cycles
    lu(5'd13, 32'h13, 1'b1);
    step();
    bus.lu_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wb(5'd2, 32'(i));
      mid(); chk("starve_no_stall", 32'(bus.stall_o), 32'd0);
      step();
    end
    wb(5'd2, 32'h55);
    mid(); chk("starve_stall", 32'(bus.stall_o), 32'd1);
    step();
    bus.wb_we_i = 1'b0;
    mid();
    chk("starve_hold", 32'(bus.stall_o), 32'd1);
    chk("starve_pop", 32'(bus.write_d_o), 32'd1);
    step();
    mid();
    chk("starve_release", 32'(bus.stall_o), 32'd0);
    chk("starve_sc_clear", 32'(dut.sc_q), 32'd0);
    step();

    // Issue to r0 never sets a busy bit
    bus.iss_lu_i = 1'b1; bus.dst_addr_i = 5'd0;
    step();
    idle_inputs();
    mid(); chk("r0_not_busy", dut.busy_q, 32'd0);
    step();

    // Same-cycle set and clear on r9: set wins
    lu(5'd9, 32'h99, 1'b1);
    step();
    idle_inputs();
    bus.iss_lu_i = 1'b1; bus.dst_addr_i = 5'd9;
    mid(); chk("r9_issue_no_stall", 32'(bus.stall_o), 32'd0);
    step();
    idle_inputs();
    bus.rs1_addr_i = 5'd9;
    mid();
    chk("r9_set_wins", 32'(dut.busy_q[9]), 32'd1);
    chk("r9_dep_stall", 32'(bus.stall_o), 32'd1);
    lu(5'd9, 32'h9A, 1'b1);
    step();
    idle_inputs();
    step();
    mid();
    chk("r9_cleared", dut.busy_q, 32'd0);
    chk("scoreboard_drained", 32'(lu_q.size()), 32'd0);
    step();

    // Reset with two entries queued and a busy bit set
    wb(5'd1, 32'h201); lu(5'd20, 32'h20, 1'b1);
    bus.iss_lu_i = 1'b1; bus.dst_addr_i = 5'd22;
    step();
    idle_inputs();
    wb(5'd1, 32'h202); lu(5'd21, 32'h21, 1'b1);
    step();
    mid(); chk("pre_rst_busy22", 32'(dut.busy_q[22]), 32'd1);
    idle_inputs();
    rst = 1'b1;
    lu(5'd23, 32'h23, 1'b0);
    lu_q.delete();
    mid();
    chk("mid_rst_write_d", 32'(bus.write_d_o), 32'd0);
    chk("mid_rst_ready", 32'(bus.lu_ready_o), 32'd0);
    step();
    rst = 1'b0;
    idle_inputs();
    mid();
    chk("post_rst_write_d", 32'(bus.write_d_o), 32'd0);
    chk("post_rst_ready", 32'(bus.lu_ready_o), 32'd1);
    chk("post_rst_busy", dut.busy_q, 32'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Write-port scheduler and scoreboard for the pipeline register file. The block shares the file's single write port between the in-order writeback stage and a long-latency unit (multiply/divide). Long-latency results wait in a small FIFO until the write port is free. A busy-bit scoreboard produces the decode-stage stall for RAW/WAW hazards on registers with results still in flight. It sits between WB, the long-latency unit, decode and the register file.

## Interface
- WIDTH, 32, data width
- R_WIDTH, 5, register address width
- REGSIZE, 32, number of architectural registers
- DEPTH, 2, long-latency result FIFO entries (power of 2, ≥2)
- STARVE_MAX, 4, cycles a FIFO head may wait before forcing a stall (≥1)

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous active-high reset
- wb_we_i  in  1  writeback stage write request
- wb_addr_i  in  R_WIDTH  writeback destination
- wb_data_i  in  WIDTH  writeback data
- lu_valid_i  in  1  long-latency result valid
- lu_addr_i  in  R_WIDTH  long-latency destination
- lu_data_i  in  WIDTH  long-latency result
- lu_ready_o  out  1  FIFO can accept a result
- rs1_addr_i, rs2_addr_i  in  R_WIDTH  decode source registers
- dst_addr_i  in  R_WIDTH  decode destination register
- iss_lu_i  in  1  decode instruction is a long-latency op
- stall_o  out  1  hold decode this cycle
- write_d_o  out  1  register file write enable
- write_addr_o  out  R_WIDTH  register file write address
- write_data_o  out  WIDTH  register file write data

## Operation
- **State:** DEPTH-entry FIFO {addr, data}, with read and write pointers and a count; busy[REGSIZE-1:0]; starvation counter sc, saturating at STARVE_MAX.
- **Write-port mux (combinational):**
  - If wb_we_i: write_*_o = wb_*.
  - Else, if FIFO non-empty: write_*_o = head, and the head pops at the edge.
  - Else: write_d_o = 0.
  - WB always has priority and is never delayed.
- **Push:** lu_valid_i && lu_ready_o at the edge. lu_ready_o = (count != DEPTH), computed from registered count only. A pop in the same cycle does not create space.
- **Simultaneous push and pop:** both take effect and count is unchanged. There is no bypass: an entry pushed at edge k is first eligible for the port in the cycle after k.
- **Scoreboard set:** at the edge, if iss_lu_i && !stall_o && dst_addr_i != 0, busy[dst_addr_i] <= 1.
- **Scoreboard clear:** at the edge a FIFO entry pops, busy[head.addr] <= 0. This is the same edge at which the register file captures the data.
  - If set and clear hit the same register in the same cycle, set wins.
- **stall_o** = busy[rs1] | busy[rs2] | busy[dst] | (sc >= STARVE_MAX). busy[0] is always 0.
- **sc:**
  - Increments while the FIFO is non-empty and wb_we_i = 1.
  - Clears to 0 on pop or when the FIFO is empty.
  - Saturates at STARVE_MAX.
  - While sc >= STARVE_MAX, stall_o forces pipeline bubbles, so WB drains and the head is written.
- **Writes to r0:** a WB or FIFO write with address 0 is still presented on the port; the file ignores it.
- **WB write to a busy register:** the write goes through and busy is unaffected. This cannot occur when stall_o is honoured.

## Timing
- During rst_i and for the cycle's outputs after it: FIFO empty, busy = 0, sc = 0.
  - While rst_i = 1: write_d_o = 0, lu_ready_o = 0, stall_o = 0.
  - Reset mid-operation discards FIFO contents and all busy bits.
- Write outputs are combinational from the same-cycle inputs and state, so WB latency is unchanged.
- Minimum LU latency: accepted at edge k, written to the file and busy cleared at edge k+1. A dependent decode is released in the cycle after k+1 and reads the new value combinationally.
- stall_o is combinational from decode addresses and registered state. It is never a function of lu_valid_i.
- FIFO full: lu_ready_o = 0, and the unit must hold its result. FIFO empty: no pop and no port use.
- Pointer wrap-around is modulo DEPTH.

## Test plan
- **Reset and idle:** rst_i for 2 cycles, then idle → write_d_o = 0, lu_ready_o = 1, stall_o = 0, busy all 0.
- **Issue and dependent stall:** issue LU op to r5; next decode rs1 = 5 → stall_o = 1. Push {5, 0xDEADBEEF} at edge k with WB idle → write_d_o = 1, addr 5, data 0xDEADBEEF in cycle k+1; stall_o = 0 after edge k+1.
- **WB priority:** FIFO holds {7, 0x11}, wb_we_i = 1 to r3 → port carries r3 and the FIFO keeps its entry. WB idle next cycle → r7 written.
- **Full FIFO:** push 2 entries while wb_we_i = 1 continuously → lu_ready_o = 0 after the second push. A third lu_valid_i is held, and is accepted only the cycle after a pop.
- **Starvation:** head pending with wb_we_i held high for 4 cycles → stall_o = 1 in the 5th cycle. Drop wb_we_i → head pops, sc = 0, stall_o = 0.
- **Edge cases:** issue to r0 → no busy bit set. Same-cycle set and clear on r9 → busy[9] = 1. rst_i with 2 entries queued → FIFO empty, write_d_o = 0 next cycle.
